intr_sequencer: RTL

Interrupt entry sequencer for the 8-bit pipelined CPU. Synchronizes the external `intr_sig`, waits for an instruction boundary, and freezes fetch while the pipeline drains. It then borrows memory port B to push the return PC and flags onto the R3 stack, and loads the PC from the interrupt vector. It sits beside `Control_unit` and the hazard unit in the CPU wrapper: its stall outputs are ANDed into the PC and IF/ID write enables, and its port-B and PC-load outputs take priority over the datapath when asserted.

---
 rtl/intr_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/intr_sequencer.sv
// Interrupt entry sequencer: synchronizes intr_sig, waits for an instruction boundary,
// drains the pipeline, pushes return PC and flags through port B, then loads the ISR vector.
module intr_sequencer #(
   parameter int         DRAIN_CYCLES = 3,
   parameter logic [7:0] VEC_ADDR     = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       intr_sig,
   input  logic       instr_boundary,
   input  logic [7:0] ret_pc,
   input  logic [3:0] ccr,
   input  logic [7:0] sp,
   input  logic       rti,
   input  logic [7:0] mem_rdata,
   output logic       pc_write_en,
   output logic       if_id_write_en,
   output logic       inject_bubble,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       sp_en,
   output logic       sp_op,
   output logic       pc_load,
   output logic [7:0] pc_vec,
   output logic       int_ack,
   output logic       in_isr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_PUSH_PC,
      S_PUSH_CCR,
      S_VEC,
      S_LOAD
   } state_t;

   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_s1;
   logic       r_s2;
   logic       r_s2_d;
   logic       r_pending;
   logic       r_in_isr;
   logic [2:0] r_cnt;
   logic [7:0] r_pc_sv;
   logic [3:0] r_ccr_sv;
   logic [7:0] r_vec;
   logic       w_edge;
   logic       w_enter;

   assign w_edge  = r_s2 & ~r_s2_d;
   assign w_enter = (r_state == S_IDLE) & r_pending & ~r_in_isr & instr_boundary;
   assign in_isr  = r_in_isr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_s2_d    <= 1'b0;
         r_pending <= 1'b0;
         r_in_isr  <= 1'b0;
         r_cnt     <= 3'd0;
         r_pc_sv   <= 8'h00;
         r_ccr_sv  <= 4'h0;
         r_vec     <= 8'h00;
      end else begin
         r_s1      <= intr_sig;
         r_s2      <= r_s1;
         r_s2_d    <= r_s2;
         // A fresh edge on the entry cycle is kept rather than lost.
         r_pending <= w_edge | (r_pending & ~w_enter);
         r_state   <= w_state_next;
         if (w_enter) begin
            r_pc_sv  <= ret_pc;
            r_ccr_sv <= ccr;
            r_cnt    <= DRAIN_INIT;
         end else if (r_state == S_DRAIN) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (r_state == S_VEC) begin
            r_vec <= mem_rdata;
         end
         if (r_state == S_LOAD) begin
            r_in_isr <= 1'b1;
         end else if (rti) begin
            r_in_isr <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      inject_bubble  = 1'b0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = 8'h00;
      mem_wdata      = 8'h00;
      sp_en          = 1'b0;
      sp_op          = 1'b0;
      pc_load        = 1'b0;
      pc_vec         = 8'h00;
      int_ack        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_enter) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            inject_bubble  = 1'b1;
            if (r_cnt == 3'd0) w_state_next = S_PUSH_PC;
         end
         S_PUSH_PC: begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_addr       = sp;
            mem_wdata      = r_pc_sv;
            sp_en          = 1'b1;
            w_state_next   = S_PUSH_CCR;
         end
         S_PUSH_CCR: begin
            // sp has already been decremented by the register file after the PC push.
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            mem_addr       = sp;
            mem_wdata      = {4'b0000, r_ccr_sv};
            sp_en          = 1'b1;
            w_state_next   = S_VEC;
         end
         S_VEC: begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            mem_req        = 1'b1;
            mem_addr       = VEC_ADDR;
            w_state_next   = S_LOAD;
         end
         S_LOAD: begin
            if_id_write_en = 1'b0;
            inject_bubble  = 1'b1;
            pc_load        = 1'b1;
            pc_vec         = r_vec;
            int_ack        = 1'b1;
            w_state_next   = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

endmodule
